// File: rtl/op_seq_if.sv
// Upstream operation request channel and datapath control outputs of op_sequencer.
// Handshake: an operation transfers on a rising clk edge where in_valid && in_ready; in_ready does not depend on in_valid.
interface op_seq_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [1:0]    in_reg;
  logic [8:0]    in_addr;
  logic          stall;
  logic [1:0]    select;
  logic [1:0]    regnumber;
  logic [8:0]    madd;
  logic          op_active;
  logic          op_done;
  logic          busy;
  logic [CW-1:0] count;
  logic          fsm_state;

  modport master (
    output in_valid, in_op, in_reg, in_addr, stall,
    input  in_ready, select, regnumber, madd, op_active, op_done, busy, count, fsm_state
  );

  modport slave (
    input  in_valid, in_op, in_reg, in_addr, stall,
    output in_ready, select, regnumber, madd, op_active, op_done, busy, count, fsm_state
  );
endinterface

// File: rtl/op_sequencer.sv
// Queues load/store/add/mul operations and holds each one on the datapath controls for a
// per-opcode number of cycles, driving the no-write code (select=10) between operations.
module op_sequencer #(
  parameter int DEPTH      = 4,
  parameter int LD_CYCLES  = 2,
  parameter int ST_CYCLES  = 2,
  parameter int ALU_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  op_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [3:0]    ctr_q, ctr_d;
  logic [1:0]    sel_q, sel_d, reg_q, reg_d;
  logic [8:0]    madd_q, madd_d;
  logic          done_q, done_d;
  logic          push, pop, in_ready;
  logic [12:0]   head;

  function automatic logic [3:0] hold_cycles(input logic [1:0] op);
    case (op)
      2'b00:   hold_cycles = 4'(LD_CYCLES - 1);
      2'b01:   hold_cycles = 4'(ST_CYCLES - 1);
      default: hold_cycles = 4'(ALU_CYCLES - 1);
    endcase
  endfunction

  // No full-bypass: a pop in the same cycle does not open a slot when full.
  assign in_ready = (cnt_q < CW'(DEPTH));
  assign push     = bus.in_valid & in_ready;
  assign pop      = (state_q == IDLE) && (cnt_q != '0);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_op, bus.in_reg, bus.in_addr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      sel_q   <= 2'b10;
      reg_q   <= '0;
      madd_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      sel_q   <= sel_d;
      reg_q   <= reg_d;
      madd_q  <= madd_d;
      done_q  <= done_d;
    end
  end

  // Datapath controls are loaded on the pop edge and restored to the idle code on the
  // completing edge, so they are registered and constant for the whole operation.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    sel_d   = sel_q;
    reg_d   = reg_q;
    madd_d  = madd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = EXEC;
          sel_d   = head[12:11];
          reg_d   = head[10:9];
          madd_d  = head[8:0];
          ctr_d   = hold_cycles(head[12:11]);
        end
      end
      EXEC: begin
        if (!bus.stall) begin
          if (ctr_q == '0) begin
            state_d = IDLE;
            sel_d   = 2'b10;
            reg_d   = '0;
            madd_d  = '0;
            done_d  = 1'b1;
          end else begin
            ctr_d = ctr_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.select    = sel_q;
  assign bus.regnumber = reg_q;
  assign bus.madd      = madd_q;
  assign bus.op_active = (state_q == EXEC);
  assign bus.op_done   = done_q;
  assign bus.busy      = (state_q != IDLE) || (cnt_q != '0);
  assign bus.count     = cnt_q;
  assign bus.fsm_state = (state_q == EXEC);
endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: cycle-exact checks of issue timing, stall, full FIFO,
// mid-operation reset and pointer wrap, plus an in-order issue scoreboard.
module tb_op_sequencer;
  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [12:0] exp_q[$];
  logic        act_prev;

  op_seq_if #(.DEPTH(4)) bus ();

  op_sequencer #(.DEPTH(4), .LD_CYCLES(2), .ST_CYCLES(2), .ALU_CYCLES(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] rg, input logic [8:0] addr);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_reg   = rg;
    bus.in_addr  = addr;
    if (bus.in_ready) exp_q.push_back({op, rg, addr});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 16'(bus.busy), 16'd0);
  endtask

  // Scoreboard: every new operation on the datapath must be the oldest accepted push.
  always @(negedge clk) begin
    if (rst) begin
      act_prev <= 1'b0;
    end else begin
      if (bus.op_active && !act_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 16'({bus.select, bus.regnumber, bus.madd}), 16'h1fff);
        end else begin
          chk("issue_order", 16'({bus.select, bus.regnumber, bus.madd}), 16'(exp_q.pop_front()));
        end
      end
      act_prev <= bus.op_active;
    end
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_reg   = '0;
    bus.in_addr  = '0;
    bus.stall    = 1'b0;
    repeat (3) tick();
    chk("rst_select", 16'(bus.select), 16'h2);
    chk("rst_regnumber", 16'(bus.regnumber), 16'h0);
    chk("rst_madd", 16'(bus.madd), 16'h0);
    chk("rst_op_active", 16'(bus.op_active), 16'h0);
    chk("rst_op_done", 16'(bus.op_done), 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_count", 16'(bus.count), 16'h0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 16'(bus.in_ready), 16'h1);

    // Single load: push c0, pop c1, EXEC c2-c3, op_done c4.
    drive(2'b00, 2'd2, 9'h005);
    tick();
    bus.in_valid = 1'b0;
    chk("ld_c1_count", 16'(bus.count), 16'd1);
    chk("ld_c1_active", 16'(bus.op_active), 16'd0);
    tick();
    chk("ld_c2_select", 16'(bus.select), 16'h0);
    chk("ld_c2_reg", 16'(bus.regnumber), 16'h2);
    chk("ld_c2_madd", 16'(bus.madd), 16'h005);
    chk("ld_c2_active", 16'(bus.op_active), 16'd1);
    chk("ld_c2_count", 16'(bus.count), 16'd0);
    tick();
    chk("ld_c3_active", 16'(bus.op_active), 16'd1);
    chk("ld_c3_select", 16'(bus.select), 16'h0);
    chk("ld_c3_busy", 16'(bus.busy), 16'd1);
    chk("ld_c3_done", 16'(bus.op_done), 16'd0);
    tick();
    chk("ld_c4_done", 16'(bus.op_done), 16'd1);
    chk("ld_c4_active", 16'(bus.op_active), 16'd0);
    chk("ld_c4_select", 16'(bus.select), 16'h2);
    tick();
    chk("ld_c5_done", 16'(bus.op_done), 16'd0);
    chk("ld_c5_busy", 16'(bus.busy), 16'd0);

    // Back-to-back add then mul with one idle cycle between.
    drive(2'b10, 2'd1, 9'h010);
    tick();
    drive(2'b11, 2'd3, 9'h1ff);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_add_select", 16'(bus.select), 16'h2);
    chk("b2b_add_reg", 16'(bus.regnumber), 16'h1);
    chk("b2b_add_active", 16'(bus.op_active), 16'd1);
    tick();
    chk("b2b_gap_select", 16'(bus.select), 16'h2);
    chk("b2b_gap_active", 16'(bus.op_active), 16'd0);
    chk("b2b_gap_done", 16'(bus.op_done), 16'd1);
    tick();
    chk("b2b_mul_select", 16'(bus.select), 16'h3);
    chk("b2b_mul_reg", 16'(bus.regnumber), 16'h3);
    chk("b2b_mul_madd", 16'(bus.madd), 16'h1ff);
    chk("b2b_mul_active", 16'(bus.op_active), 16'd1);
    tick();
    chk("b2b_end_done", 16'(bus.op_done), 16'd1);
    wait_idle("b2b_idle");

    // Full FIFO behind a stalled store.
    drive(2'b01, 2'd0, 9'h020);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.stall = 1'b1;
    chk("full_store_active", 16'(bus.op_active), 16'd1);
    for (int i = 0; i < 5; i++) begin
      drive(2'(i), 2'(i + 1), 9'(16'h031 + 16'(i) * 16'h011));
      chk("full_in_ready", 16'(bus.in_ready), (i < 4) ? 16'd1 : 16'd0);
      if (i == 4) chk("full_count", 16'(bus.count), 16'd4);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("full_store_held", 16'(bus.op_active), 16'd1);
    chk("full_store_select", 16'(bus.select), 16'h1);
    bus.stall = 1'b0;
    wait_idle("full_drain");
    chk("full_count_end", 16'(bus.count), 16'd0);
    chk("full_exp_empty", 16'(exp_q.size()), 16'd0);

    // Stall a load for three cycles: active for 2+3 cycles, one op_done.
    drive(2'b00, 2'd3, 9'h0aa);
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_active", 16'(bus.op_active), 16'd1);
      chk("stall_madd", 16'(bus.madd), 16'h0aa);
      chk("stall_done", 16'(bus.op_done), 16'd0);
      bus.stall = (i < 3);
      tick();
    end
    bus.stall = 1'b0;
    chk("stall_end_active", 16'(bus.op_active), 16'd0);
    chk("stall_end_done", 16'(bus.op_done), 16'd1);
    tick();
    chk("stall_done_pulse", 16'(bus.op_done), 16'd0);

    // Reset in the second cycle of a store with two operations queued.
    drive(2'b01, 2'd2, 9'h123);
    tick();
    drive(2'b00, 2'd1, 9'h044);
    tick();
    drive(2'b10, 2'd0, 9'h055);
    tick();
    bus.in_valid = 1'b0;
    chk("rmid_count", 16'(bus.count), 16'd2);
    chk("rmid_active", 16'(bus.op_active), 16'd1);
    rst = 1'b1;
    #1;
    chk("rmid_select", 16'(bus.select), 16'h2);
    chk("rmid_active_rst", 16'(bus.op_active), 16'd0);
    chk("rmid_count_rst", 16'(bus.count), 16'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rmid_no_issue", 16'(bus.op_active), 16'd0);
      chk("rmid_in_ready", 16'(bus.in_ready), 16'd1);
    end

    // Wrap-around: ten operations with random in_valid.
    begin
      int pushed = 0;
      int budget = 0;
      while (pushed < 10 && budget < 300) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_op    = 2'(pushed);
        bus.in_reg   = 2'(pushed >> 1);
        bus.in_addr  = 9'(pushed * 37 + 3);
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back({bus.in_op, bus.in_reg, bus.in_addr});
          pushed++;
        end
        chk("wrap_count_max", 16'(bus.count <= 3'd4), 16'd1);
        tick();
        budget++;
      end
      bus.in_valid = 1'b0;
      chk("wrap_pushed", 16'(pushed), 16'd10);
    end
    wait_idle("wrap_drain");
    chk("wrap_exp_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
